// File: rtl/drv_segment_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Results saturate to all nines when the operand does not fit in p_count digits.
module drv_segment_bin2bcd_seq #(
  parameter int unsigned p_count = 4,
  parameter int unsigned p_width = 14
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [p_width-1:0] i_value,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_ovf,
  output logic [3:0]         o_bcd [p_count-1:0]
);

  localparam int unsigned ScratchW = 4 * p_count;
  localparam int unsigned CntW     = $clog2(p_width + 1);

  function automatic logic [63:0] max_decimal(input int unsigned digits);
    logic [63:0] acc;
    acc = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      acc = acc * 64'd10;
    end
    return acc - 64'd1;
  endfunction

  localparam logic [63:0] MaxDec = max_decimal(p_count);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [p_width-1:0]    operand_q, operand_d;
  logic [ScratchW-1:0]   scratch_q, scratch_d;
  logic [ScratchW-1:0]   adjusted;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_lat_q, ovf_lat_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic [3:0]            bcd_q [p_count-1:0];
  logic [3:0]            bcd_d [p_count-1:0];

  always_comb begin
    for (int unsigned i = 0; i < p_count; i++) begin
      adjusted[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                          : scratch_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          operand_d = i_value;
          scratch_d = '0;
          cnt_d     = CntW'(p_width);
          ovf_lat_d = (64'(i_value) > MaxDec);
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = {adjusted[ScratchW-2:0], operand_q[p_width-1]};
        operand_d = operand_q << 1;
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        for (int unsigned i = 0; i < p_count; i++) begin
          bcd_d[i] = ovf_lat_q ? 4'd9 : scratch_q[4*i +: 4];
        end
        ovf_d   = ovf_lat_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      operand_q <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      for (int unsigned i = 0; i < p_count; i++) begin
        bcd_q[i] <= 4'd0;
      end
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;
  assign o_bcd   = bcd_q;

endmodule

// File: tb/tb_drv_segment_bin2bcd_seq.sv
// Self-checking bench for drv_segment_bin2bcd_seq (p_count=4, p_width=14).
// Reference results come from decimal arithmetic with saturation above 9999.
module tb_drv_segment_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] value;
  logic        busy;
  logic        valid;
  logic        ovf;
  logic [3:0]  bcd [3:0];

  int n_cmp;
  int n_err;

  drv_segment_bin2bcd_seq #(
    .p_count(4),
    .p_width(14)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_value(value),
    .o_busy (busy),
    .o_valid(valid),
    .o_ovf  (ovf),
    .o_bcd  (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input int unsigned v);
    logic [15:0] r;
    int unsigned div;
    if (v > 9999) return 16'h9999;
    div = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_word();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = bcd[i];
    return r;
  endfunction

  // Pulse start for one edge, scramble the operand, then wait for o_valid.
  task automatic start_and_wait(input logic [13:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 14'($urandom);
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, valid, ovf, bcd_word()} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b valid=%b ovf=%b bcd=%h, want all zero",
               busy, valid, ovf, bcd_word());
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, valid, ovf, bcd_word()} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b valid=%b ovf=%b bcd=%h, want all zero",
               busy, valid, ovf, bcd_word());
    end
  endtask

  task automatic test_directed();
    int unsigned vals [4] = '{1234, 9999, 0, 10000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(14'(vals[i]), lat);
      n_cmp++;
      if (lat != 15) begin
        n_err++;
        $display("FAIL directed_latency(%0d): got %0d cycles, want 15", vals[i], lat);
      end
      n_cmp++;
      if (bcd_word() !== model(vals[i]) || ovf !== (vals[i] > 9999) || busy !== 1'b0) begin
        n_err++;
        $display("FAIL directed_result(%0d): got bcd=%h ovf=%b busy=%b, want bcd=%h ovf=%b busy=0",
                 vals[i], bcd_word(), ovf, busy, model(vals[i]), vals[i] > 9999);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_pulse_width(%0d): got valid=%b, want 0", vals[i], valid);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    int first_at;
    logic [15:0] res;
    pulses   = 0;
    first_at = -1;
    res      = '0;
    @(negedge clk);
    start = 1'b1;
    value = 14'd42;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        start = 1'b1;
        value = 14'd7777;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (n == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_asserted: got %b, want 1", busy);
        end
      end
      if (valid) begin
        pulses++;
        if (first_at < 0) begin
          first_at = n;
          res      = bcd_word();
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (pulses != 1 || first_at != 15 || res !== 16'h0042) begin
      n_err++;
      $display("FAIL ignore_busy: got pulses=%0d at=%0d bcd=%h, want pulses=1 at=15 bcd=0042",
               pulses, first_at, res);
    end
  endtask

  task automatic test_back_to_back();
    int          at [$];
    logic [15:0] res [$];
    int          nxt;
    nxt = 2;
    @(negedge clk);
    start = 1'b1;
    value = 14'd1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 80 && at.size() < 3; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        at.push_back(n);
        res.push_back(bcd_word());
        if (nxt <= 3) begin
          value = 14'(nxt);
          nxt++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (at.size() != 3) begin
      n_err++;
      $display("FAIL back_to_back_count: got %0d pulses, want 3", at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (at[i] != 15 + 16 * i || res[i] !== model(i + 1)) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: got at=%0d bcd=%h, want at=%0d bcd=%h",
                   i, at[i], res[i], 15 + 16 * i, model(i + 1));
        end
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    value = 14'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: got busy=%b valid=%b, want 0 0", busy, valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || bcd_word() !== 16'h0000 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL abort_quiet: got pulses=%0d bcd=%h busy=%b ovf=%b, want 0 0000 0 0",
               pulses, bcd_word(), busy, ovf);
    end
    start_and_wait(14'd5678, lat);
    n_cmp++;
    if (lat != 15 || bcd_word() !== 16'h5678) begin
      n_err++;
      $display("FAIL abort_restart: got lat=%0d bcd=%h, want lat=15 bcd=5678", lat, bcd_word());
    end
  endtask

  task automatic test_random();
    int unsigned v;
    int          lat;
    logic [15:0] held;
    for (int t = 0; t < 60; t++) begin
      v = (t == 0) ? 16383 : $urandom_range(0, 16383);
      start_and_wait(14'(v), lat);
      n_cmp++;
      if (lat != 15) begin
        n_err++;
        $display("FAIL random_latency(%0d): got %0d, want 15", v, lat);
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (bcd[i] > 4'd9) begin
          n_err++;
          $display("FAIL random_digit_range(%0d)[%0d]: got %0d, want <= 9", v, i, bcd[i]);
        end
      end
      n_cmp++;
      if (bcd_word() !== model(v) || ovf !== (v > 9999)) begin
        n_err++;
        $display("FAIL random_value(%0d): got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                 v, bcd_word(), ovf, model(v), v > 9999);
      end
      held = bcd_word();
      value = 14'($urandom);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      n_cmp++;
      if (bcd_word() !== held || ovf !== (v > 9999)) begin
        n_err++;
        $display("FAIL random_hold(%0d): got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                 v, bcd_word(), ovf, held, v > 9999);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
